// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: a single-cycle source A and a multi-cycle source B
// buffered in a 2-entry skid FIFO share one registered write port, with B starvation relief.
module wb_arbiter #(
  parameter int D_BITS       = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [2:0]        a_dest,
  input  logic [D_BITS-1:0] a_value,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [2:0]        b_dest,
  input  logic [D_BITS-1:0] b_value,
  output logic              b_ready,
  output logic              wr_en,
  output logic [2:0]        wr_dest,
  output logic [D_BITS-1:0] wr_value,
  output logic [7:0]        b_pending
);

  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  // FIFO storage and control
  logic [2:0]        dest_mem_q  [2];
  logic [2:0]        dest_mem_d  [2];
  logic [D_BITS-1:0] value_mem_q [2];
  logic [D_BITS-1:0] value_mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [1:0]        wait_q, wait_d;

  // Registered write port
  logic              wr_en_q, wr_en_d;
  logic [2:0]        wr_dest_q, wr_dest_d;
  logic [D_BITS-1:0] wr_value_q, wr_value_d;

  logic fifo_nonempty;
  logic force_b;
  logic sel_a;
  logic sel_b;
  logic push;
  logic pop;

  // Only entries present at the start of the cycle compete, so a push is never
  // granted in the same cycle it arrives.
  assign fifo_nonempty = (count_q != 2'd0);
  assign force_b       = fifo_nonempty && (wait_q == LIMIT);
  assign sel_b         = force_b || (!a_valid && fifo_nonempty);
  assign sel_a         = !force_b && a_valid;
  assign push          = b_valid && (count_q < 2'd2);
  assign pop           = sel_b;

  assign a_ready = !force_b;
  assign b_ready = (count_q < 2'd2);

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_d    = rd_ptr_q ^ pop;
    wr_ptr_d    = wr_ptr_q ^ push;
    count_d     = count_q + 2'(push) - 2'(pop);
    dest_mem_d  = dest_mem_q;
    value_mem_d = value_mem_q;
    if (push) begin
      dest_mem_d[wr_ptr_q]  = b_dest;
      value_mem_d[wr_ptr_q] = b_value;
    end
  end

  // The head's loss counter restarts whenever the head changes or the FIFO drains.
  always_comb begin
    wait_d = wait_q;
    if (!fifo_nonempty || sel_b) begin
      wait_d = 2'd0;
    end else if (wait_q != LIMIT) begin
      wait_d = wait_q + 2'd1;
    end
  end

  always_comb begin
    wr_en_d    = sel_a || sel_b;
    wr_dest_d  = wr_dest_q;
    wr_value_d = wr_value_q;
    if (sel_b) begin
      wr_dest_d  = dest_mem_q[rd_ptr_q];
      wr_value_d = value_mem_q[rd_ptr_q];
    end else if (sel_a) begin
      wr_dest_d  = a_dest;
      wr_value_d = a_value;
    end
  end

  always_comb begin
    b_pending = '0;
    for (int i = 0; i < 2; i++) begin
      if (2'(i) < count_q) begin
        b_pending[dest_mem_q[rd_ptr_q ^ 1'(i)]] = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      wait_q     <= 2'd0;
      wr_en_q    <= 1'b0;
      wr_dest_q  <= '0;
      wr_value_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      wr_en_q    <= wr_en_d;
      wr_dest_q  <= wr_dest_d;
      wr_value_q <= wr_value_d;
    end
  end

  // NOTE: the storage array has no reset; count_q gates every read of it, so stale
  // contents are never observed and the array maps onto plain registers or RAM.
  always_ff @(posedge clk) begin
    dest_mem_q  <= dest_mem_d;
    value_mem_q <= value_mem_d;
  end

  assign wr_en    = wr_en_q;
  assign wr_dest  = wr_dest_q;
  assign wr_value = wr_value_q;

endmodule
